// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: size/sign codes, FSM states,
// and helpers that classify an access by its code and low address bits.
package lsu_pkg;

    localparam logic [2:0] LS_WORD  = 3'b000;
    localparam logic [2:0] LS_BYTE  = 3'b001;
    localparam logic [2:0] LS_HALF  = 3'b010;
    localparam logic [2:0] LS_BYTEU = 3'b011;
    localparam logic [2:0] LS_HALFU = 3'b100;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic logic ls_is_legal(input logic [2:0] code);
        return code <= LS_HALFU;
    endfunction

    function automatic lsu_size_e ls_size(input logic [2:0] code);
        case (code)
            LS_BYTE, LS_BYTEU: return SZ_BYTE;
            LS_HALF, LS_HALFU: return SZ_HALF;
            default:           return SZ_WORD;
        endcase
    endfunction

    // Only meaningful for legal codes; illegal codes are rejected before this is consulted.
    function automatic logic ls_is_misaligned(input logic [2:0] code, input logic [1:0] addr_lo);
        case (ls_size(code))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  code_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (code_i)
            LS_BYTE:  result_o = {{24{byte_sel[7]}}, byte_sel};
            LS_BYTEU: result_o = {24'h000000, byte_sel};
            LS_HALF:  result_o = {{16{half_sel[15]}}, half_sel};
            LS_HALFU: result_o = {16'h0000, half_sel};
            default:  result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: one req/ack data-memory transaction per start,
// with alignment/legality checks, an ack timeout and an aligned, extended load result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_write,
    input  logic [2:0]  load_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        misaligned,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    // Wait-counter value in the last ACCESS cycle before giving up.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       code_q;
    logic [1:0]       addr_lo_q;
    logic             we_q;

    logic             done_q;
    logic             misaligned_q;
    logic             bus_error_q;
    logic [31:0]      load_result_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic [31:0]      dmem_addr_q;
    logic [3:0]       dmem_be_q;
    logic [31:0]      dmem_wdata_q;

    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [31:0]      aligned_rdata;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        case (ls_size(load_store))
            SZ_BYTE: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be_d    = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_lo_q),
        .code_i    (code_q),
        .result_o  (aligned_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            code_q        <= LS_WORD;
            addr_lo_q     <= 2'b00;
            we_q          <= 1'b0;
            done_q        <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_error_q   <= 1'b0;
            load_result_q <= 32'h0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 32'h0;
            dmem_be_q     <= 4'h0;
            dmem_wdata_q  <= 32'h0;
        end else begin
            // Completion flags are pulses; they only rise on the transition into DONE.
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        code_q    <= load_store;
                        addr_lo_q <= addr[1:0];
                        we_q      <= mem_write;
                        if (!ls_is_legal(load_store)) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            bus_error_q <= 1'b1;
                        end else if (ls_is_misaligned(load_store, addr[1:0])) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q      <= ST_ACCESS;
                            cnt_q        <= '0;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= mem_write;
                            dmem_addr_q  <= {addr[31:2], 2'b00};
                            dmem_be_q    <= be_d;
                            dmem_wdata_q <= wdata_d;
                        end
                    end
                end

                ST_ACCESS: begin
                    // An ack in the timeout cycle still wins and completes normally.
                    if (dmem_ack) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (!we_q) begin
                            load_result_q <= aligned_rdata;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                        dmem_req_q  <= 1'b0;
                        dmem_we_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign misaligned  = misaligned_q;
    assign bus_error   = bus_error_q;
    assign load_result = load_result_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_be     = dmem_be_q;
    assign dmem_wdata  = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a per-transaction behavioural model sets the
// expected outputs for each cycle, and a negedge compare process checks the DUT against them.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_write;
    logic [2:0]  load_store;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_result;
    logic        misaligned;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_write   (mem_write),
        .load_store  (load_store),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_result (load_result),
        .misaligned  (misaligned),
        .bus_error   (bus_error),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic        exp_busy, exp_done, exp_mis, exp_err, exp_req, exp_we, exp_wchk, exp_zero;
    logic [31:0] exp_addr, exp_wdata, exp_lr;
    logic [3:0]  exp_be;
    logic [31:0] model_lr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] code, input logic [31:0] a);
        case (code)
            3'd1, 3'd3: return 4'b0001 << a[1:0];
            3'd2, 3'd4: return a[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] code, input logic [31:0] sd);
        case (code)
            3'd1, 3'd3: return {4{sd[7:0]}};
            3'd2, 3'd4: return {2{sd[15:0]}};
            default:    return sd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] code, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = rd >> (8 * int'(a[1:0]));
        h = rd >> (16 * int'(a[1]));
        case (code)
            3'd1:    return {{24{b[7]}}, b[7:0]};
            3'd3:    return {24'h0, b[7:0]};
            3'd2:    return {{16{h[15]}}, h[15:0]};
            3'd4:    return {16'h0, h[15:0]};
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",        32'(busy),       32'(exp_busy));
            check("done",        32'(done),       32'(exp_done));
            check("misaligned",  32'(misaligned), 32'(exp_mis));
            check("bus_error",   32'(bus_error),  32'(exp_err));
            check("dmem_req",    32'(dmem_req),   32'(exp_req));
            check("load_result", load_result,     exp_lr);
            if (exp_req) begin
                check("dmem_we",   32'(dmem_we), 32'(exp_we));
                check("dmem_addr", dmem_addr,    exp_addr);
                check("dmem_be",   32'(dmem_be), 32'(exp_be));
                if (exp_wchk) check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (exp_zero) begin
                check("rst_we",    32'(dmem_we), 32'h0);
                check("rst_addr",  dmem_addr,    32'h0);
                check("rst_be",    32'(dmem_be), 32'h0);
                check("rst_wdata", dmem_wdata,   32'h0);
            end
        end
    end

    task automatic set_idle_exp();
        exp_busy = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        exp_req  = 1'b0; exp_we = 1'b0; exp_wchk = 1'b0; exp_zero = 1'b0;
        exp_lr   = model_lr;
    endtask

    // One transaction; ack arrives in cycle k after the start edge (k > T means never).
    task automatic run_txn(input bit we, input logic [2:0] code, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int k, input bit poke);
        bit illegal = (code > 3'd4);
        bit is_half = (code == 3'd2) || (code == 3'd4);
        bit is_word = (code == 3'd0);
        bit mis     = !illegal && ((is_half && a[0]) || (is_word && a[1:0] != 2'b00));
        bit access  = !illegal && !mis;
        bit to      = access && (k > T);
        int last    = !access ? 1 : (k <= T ? k + 1 : T + 1);

        @(posedge clk); #1;
        start = 1'b1; mem_write = we; load_store = code; addr = a; store_data = sd;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        set_idle_exp();

        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start = poke && ($urandom_range(0, 2) == 0);
            if (start) begin
                mem_write = 1'($urandom); load_store = 3'($urandom);
                addr = $urandom; store_data = $urandom;
            end
            dmem_ack   = access && (c == k);
            dmem_rdata = (c == k) ? rd : $urandom;
            exp_busy  = 1'b1;
            exp_req   = access && (c < last);
            exp_done  = (c == last);
            exp_mis   = (c == last) && mis;
            exp_err   = (c == last) && (illegal || to);
            exp_we    = we;
            exp_wchk  = we;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = model_be(code, a);
            exp_wdata = model_wdata(code, sd);
            if (c == last && access && !to && !we) model_lr = model_load(code, a, rd);
            exp_lr = model_lr;
        end
        start = 1'b0;
    endtask

    task automatic reset_mid_access(input logic [31:0] a);
        @(posedge clk); #1;
        start = 1'b1; mem_write = 1'b0; load_store = 3'd0; addr = a; dmem_ack = 1'b0;
        set_idle_exp();
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = {a[31:2], 2'b00}; exp_be = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        reset = 1'b0; dmem_ack = 1'b0;
        model_lr = 32'h0;
        set_idle_exp();
        exp_zero = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_write = 1'b0; load_store = 3'd0;
        addr = 32'h0; store_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        model_lr = 32'h0;
        set_idle_exp();

        // Model pins against hand-computed values.
        check("pin_lb",       model_load(3'd1, 32'h2002, 32'h80F00000), 32'hFFFFFFF0);
        check("pin_lbu",      model_load(3'd3, 32'h2002, 32'h80F00000), 32'h000000F0);
        check("pin_lh_hi",    model_load(3'd2, 32'h2002, 32'h80F00000), 32'hFFFF80F0);
        check("pin_sb_be",    32'(model_be(3'd1, 32'h1003)), 32'h8);
        check("pin_sb_wdata", model_wdata(3'd1, 32'h000000A5), 32'hA5A5A5A5);

        @(posedge clk); #1;
        exp_zero = 1'b1;
        chk_en   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(1'b1, 3'd1, 32'h1003, 32'h000000A5, 32'h0, 1, 1'b0);
        check("sb_done_lit",  32'(done), 32'h1);
        run_txn(1'b0, 3'd1, 32'h2002, 32'h0, 32'h80F00000, 3, 1'b0);
        check("lb_lit", load_result, 32'hFFFFFFF0);
        run_txn(1'b0, 3'd3, 32'h2002, 32'h0, 32'h80F00000, 3, 1'b0);
        check("lbu_lit", load_result, 32'h000000F0);
        run_txn(1'b0, 3'd2, 32'h2001, 32'h0, 32'h12345678, 1, 1'b0);
        check("lh_mis_lit", 32'(misaligned), 32'h1);
        run_txn(1'b0, 3'd0, 32'h2002, 32'h0, 32'h12345678, 1, 1'b0);
        check("lw_mis_lr_lit", load_result, 32'h000000F0);
        run_txn(1'b0, 3'd0, 32'h3000, 32'h0, 32'h11111111, 99, 1'b0);
        check("timeout_lit", 32'(bus_error), 32'h1);
        run_txn(1'b0, 3'd0, 32'h3004, 32'h0, 32'hCAFEF00D, T, 1'b0);
        check("ack_at_timeout_lit", load_result, 32'hCAFEF00D);
        run_txn(1'b0, 3'd5, 32'h4000, 32'h0, 32'h0, 1, 1'b0);
        run_txn(1'b1, 3'd2, 32'h5002, 32'h0000BEEF, 32'h0, 2, 1'b1);

        reset_mid_access(32'h6000);
        run_txn(1'b0, 3'd4, 32'h7002, 32'h0, 32'h9ABC1234, 2, 1'b0);
        check("post_rst_lit", load_result, 32'h00009ABC);

        for (int i = 0; i < 80; i++) begin
            run_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    $urandom_range(1, T + 2), 1'b1);
        end

        @(posedge clk); #1;
        set_idle_exp();
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the RV32I memory stage. Consumes the effective address produced by the ALU, the rs2 store data, and the 3-bit `load_store` size/sign code produced by the ALU decoder. It runs one request/acknowledge transaction on the data-memory port, with word-aligned address, byte enables and lane-replicated write data. It then returns the aligned, sign- or zero-extended load result and stalls the pipeline through `busy` until the access completes.

## Interface
- TIMEOUT_CYCLES, 255, cycles to wait in ACCESS for `dmem_ack` before aborting; legal range 1..65535.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mem_write  in  1  1 = store, 0 = load
- load_store  in  3  000 word, 001 byte signed / sb, 010 half signed / sh, 011 byte unsigned, 100 half unsigned; 101..111 illegal
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value
- busy  out  1  high from the cycle after an accepted `start` through the DONE cycle
- done  out  1  one-cycle completion pulse
- load_result  out  32  extended load data; valid with `done`, held until the next accepted `start`
- misaligned  out  1  valid with `done`
- bus_error  out  1  valid with `done`
- dmem_req  out  1  memory request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  `{addr[31:2],2'b00}`
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  memory acknowledge; `dmem_rdata` is valid in the same cycle
- dmem_rdata  in  32  read word

## Operation
- **States.** IDLE, ACCESS, DONE.
- **IDLE, accepted `start`.** Register `addr`, `store_data`, `mem_write` and `load_store`. Then check, in this priority order:
  - Illegal code: go to DONE with `bus_error`=1. No memory access.
  - Misaligned access (half with `addr[0]`=1, or word with `addr[1:0]`≠0): go to DONE with `misaligned`=1. No memory access.
  - Otherwise: go to ACCESS.
- **`start` outside IDLE.** Ignored; no queuing.
- **ACCESS.**
  - `dmem_req`=1, held stable with `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` until `dmem_ack`.
  - On `dmem_ack`: capture `dmem_rdata` (loads only) and go to DONE.
- **Timeout.** A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without `dmem_ack`.
  - When it reaches TIMEOUT_CYCLES, drop `dmem_req` and go to DONE with `bus_error`=1.
  - `load_result` stays unchanged.
  - `dmem_ack` arriving in that same cycle takes priority: the access completes normally.
- **DONE.** `done`=1 for exactly one cycle, then return to IDLE.
- **Byte enables.**
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `4'b0011<<{addr[1],1'b0}`.
  - Word: `4'b1111`.
  - Loads drive the same enables with `dmem_we`=0.
- **Write data.**
  - sb: `{4{store_data[7:0]}}`.
  - sh: `{2{store_data[15:0]}}`.
  - sw: `store_data`.
- **Load extraction.**
  - Byte: select `rdata[8*addr[1:0]+:8]`.
  - Half: select `rdata[16*addr[1]+:16]`.
  - Extension: sign-extend for codes 001/010, zero-extend for 011/100. Words pass through unchanged.
- **Stores.** `load_result` is unchanged by a store.
- **Flags.** `misaligned` and `bus_error` are low whenever `done` is low.
- **Reset.** All outputs 0, state IDLE, counter 0.
  - Reset asserted mid-ACCESS drops `dmem_req` at that edge.
  - An acknowledge arriving in the reset cycle is discarded.

## Timing
- `start` accepted at edge 0.
- Aligned access:
  - `dmem_req` high from cycle 1.
  - If `dmem_ack` is high in cycle k (k≥1), `done` is high in cycle k+1.
  - Best-case latency: `start` to `done` = 2 cycles.
- Misaligned or illegal access: `done` in cycle 1 and `dmem_req` never asserted.
- Timeout: `done` in cycle TIMEOUT_CYCLES+1.
- Back-to-back: the next `start` can be accepted in the cycle after DONE, once IDLE is re-entered; minimum issue interval is 3 cycles.
- All outputs are registered except `busy`, which is a decode of state ≠ IDLE.

## Structure
- Shared package `lsu_pkg`:
  - `load_store` encoding constants (LS_WORD, LS_BYTE, LS_HALF, LS_BYTEU, LS_HALFU), shared with the ALU decoder.
  - State enum.
  - Counter width constant (16).
- One combinational sub-module, `lsu_load_align`: `rdata`, `addr[1:0]`, code in; 32-bit extended result out.
- FSM, timeout counter and byte-enable / write-data generation live in the top module.

## Test plan
- **sb.** `addr`=0x1003, `store_data`=0x000000A5, code 001, store, ack at cycle 1 → `dmem_addr`=0x1000, `dmem_be`=1000, `dmem_wdata`=0xA5A5A5A5, `done` at cycle 2, no flags.
- **lb / lbu.** `rdata`=0x80F00000, `addr`=0x2002, ack at cycle 3:
  - lb (001) → `load_result`=0xFFFFFFF0, `done` at cycle 4.
  - lbu (011) → `load_result`=0x000000F0.
- **Misaligned.** lh (010) at `addr`=0x2001 → `dmem_req` never high, `done`+`misaligned` at cycle 1, `load_result` unchanged. Repeat with lw at 0x2002: same result.
- **Timeout.** TIMEOUT_CYCLES=4, no ack → `dmem_req` high cycles 1–4, `done`+`bus_error` at cycle 5. Then ack arriving exactly at the timeout cycle → normal completion, no error.
- **Illegal code.** Code 101 → `done`+`bus_error` at cycle 1, no request.
- **Reset and `start` while busy.**
  - Reset asserted mid-ACCESS → `dmem_req` 0 at the next edge, all outputs 0, the next access completes correctly.
  - `start` pulsed while busy → ignored.
